neg_regfile: RTL and testbench

- Parametrised multi-entry register file built from negedge-write storage; successor to the single-bit negedge DFFE.
- Serves as operand/twiddle/sample storage in the FFT datapath. Writes land on the falling edge, so posedge-clocked consumers read updated data in the same cycle.
- Adds WIDTH/DEPTH generalisation, two asynchronous read ports, optional hardwired-zero entry, and a per-entry busy scoreboard for pending producers.

---
 rtl/neg_regfile_pkg.sv | 12 +
 rtl/dffe_neg_vec.sv | 21 ++
 rtl/neg_regfile.sv | 92 +++++++++
 tb/tb_neg_regfile.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neg_regfile_pkg.sv
// Shared constants and helpers for the negedge register file.
// The NEG_REGFILE_BYPASS_EN macro enables write-to-read bypass in neg_regfile.
package neg_regfile_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int DEPTH_DEF = 32;
   localparam int WR_COUNT_W = 16;
   localparam logic [WR_COUNT_W-1:0] WR_COUNT_MAX = '1;

   function automatic int addr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction
endpackage

// File: rtl/dffe_neg_vec.sv
// WIDTH-bit falling-edge register with enable and asynchronous active-high clear.
module dffe_neg_vec
   import neg_regfile_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(negedge clk or posedge clr) begin
      if (clr)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/neg_regfile.sv
// Negedge-write register file: two combinational read ports, busy scoreboard, saturating write count.
// Define NEG_REGFILE_BYPASS_EN to forward in-flight write data to the read ports.
module neg_regfile
   import neg_regfile_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int ADDR_W   = addr_width(DEPTH),
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  busy_set,
   input  logic [ADDR_W-1:0]     busy_addr,
   input  logic [ADDR_W-1:0]     raddr_a,
   output logic [WIDTH-1:0]      rdata_a,
   output logic                  busy_a,
   input  logic [ADDR_W-1:0]     raddr_b,
   output logic [WIDTH-1:0]      rdata_b,
   output logic                  busy_b,
   output logic [WR_COUNT_W-1:0] wr_count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] busy;
   logic             wr_ok;
   logic             set_ok;

   function automatic logic writable(input logic [ADDR_W-1:0] a);
      return (ZERO_REG == 0) || (a != '0);
   endfunction

   function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] c);
      return (c == WR_COUNT_MAX) ? c : c + WR_COUNT_W'(1);
   endfunction

   assign wr_ok  = we & writable(waddr);
   assign set_ok = busy_set & writable(busy_addr);

   // entry 0 never sees an enable when hardwired to zero, so it stays at its reset value
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      dffe_neg_vec #(.WIDTH(WIDTH)) u_entry (
         .clk (clk),
         .clr (clr),
         .en  (wr_ok && (waddr == ADDR_W'(i))),
         .d   (wdata),
         .q   (mem[i])
      );
   end

   // a new producer supersedes the one completing in the same cycle
   always_ff @(negedge clk or posedge clr) begin
      if (clr) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (set_ok && (busy_addr == ADDR_W'(i)))
               busy[i] <= 1'b1;
            else if (wr_ok && (waddr == ADDR_W'(i)))
               busy[i] <= 1'b0;
         end
      end
   end

   always_ff @(negedge clk or posedge clr) begin
      if (clr)
         wr_count <= '0;
      else if (wr_ok)
         wr_count <= sat_inc(wr_count);
   end

`ifdef NEG_REGFILE_BYPASS_EN
   logic byp_a;
   logic byp_b;

   assign byp_a   = wr_ok && (waddr == raddr_a);
   assign byp_b   = wr_ok && (waddr == raddr_b);
   assign rdata_a = byp_a ? wdata : mem[raddr_a];
   assign rdata_b = byp_b ? wdata : mem[raddr_b];
   assign busy_a  = byp_a ? (set_ok && (busy_addr == raddr_a)) : busy[raddr_a];
   assign busy_b  = byp_b ? (set_ok && (busy_addr == raddr_b)) : busy[raddr_b];
`else
   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];
   assign busy_a  = busy[raddr_a];
   assign busy_b  = busy[raddr_b];
`endif

endmodule

// File: tb/tb_neg_regfile.sv
// Scoreboard bench for neg_regfile: a ZERO_REG=1 instance plus a ZERO_REG=0 instance on shared inputs.
module tb_neg_regfile;

   logic        clk = 1'b0;
   logic        clr;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        busy_set;
   logic [4:0]  busy_addr;
   logic [4:0]  raddr_a;
   logic [4:0]  raddr_b;
   logic [31:0] rdata_a, rdata_b, nz_rdata_a, nz_rdata_b;
   logic        busy_a, busy_b, nz_busy_a, nz_busy_b;
   logic [15:0] wr_count, nz_wr_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;
   exp_t exp_q[$];

   logic [31:0] m_mem [32];
   logic [31:0] m_busy;
   logic [15:0] m_cnt;
   logic [31:0] nz0;
   logic [15:0] nz_cnt;

   neg_regfile #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
      .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .busy_set(busy_set), .busy_addr(busy_addr),
      .raddr_a(raddr_a), .rdata_a(rdata_a), .busy_a(busy_a),
      .raddr_b(raddr_b), .rdata_b(rdata_b), .busy_b(busy_b),
      .wr_count(wr_count)
   );

   neg_regfile #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) dut_nz (
      .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .busy_set(busy_set), .busy_addr(busy_addr),
      .raddr_a(raddr_a), .rdata_a(nz_rdata_a), .busy_a(nz_busy_a),
      .raddr_b(raddr_b), .rdata_b(nz_rdata_b), .busy_b(nz_busy_b),
      .wr_count(nz_wr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sat(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         0:       return rdata_a;
         1:       return rdata_b;
         2:       return {31'd0, busy_a};
         3:       return {31'd0, busy_b};
         4:       return {16'd0, wr_count};
         5:       return nz_rdata_a;
         default: return {16'd0, nz_wr_count};
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_busy = '0;
      m_cnt  = '0;
      nz0    = '0;
      nz_cnt = '0;
   endtask

   task automatic push(input string tag, input int sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      exp_q.push_back(e);
   endtask

   task automatic push_all(input string tag);
      push({tag, ".rdata_a"}, 0, m_mem[raddr_a]);
      push({tag, ".rdata_b"}, 1, m_mem[raddr_b]);
      push({tag, ".busy_a"}, 2, {31'd0, m_busy[raddr_a]});
      push({tag, ".busy_b"}, 3, {31'd0, m_busy[raddr_b]});
      push({tag, ".wr_count"}, 4, {16'd0, m_cnt});
      push({tag, ".nz_rdata_a"}, 5, (raddr_a == 5'd0) ? nz0 : m_mem[raddr_a]);
      push({tag, ".nz_wr_count"}, 6, {16'd0, nz_cnt});
   endtask

   task automatic drain();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic bs, input logic [4:0] ba,
                        input logic [4:0] ra, input logic [4:0] rb);
      we        = w;
      waddr     = wa;
      wdata     = wd;
      busy_set  = bs;
      busy_addr = ba;
      raddr_a   = ra;
      raddr_b   = rb;
      #1;
   endtask

   // one negedge: update the model, release strobes, then score all outputs
   task automatic commit(input string tag);
      @(negedge clk);
      if (we) begin
         nz_cnt = sat(nz_cnt);
         if (waddr == 5'd0) nz0 = wdata;
         else begin
            m_mem[waddr]  = wdata;
            m_busy[waddr] = 1'b0;
            m_cnt         = sat(m_cnt);
         end
      end
      if (busy_set && busy_addr != 5'd0) m_busy[busy_addr] = 1'b1;
      #1;
      we       = 1'b0;
      busy_set = 1'b0;
      #1;
      push_all(tag);
      drain();
   endtask

   initial begin
      clr = 1'b1;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("init.rdata_a", rdata_a, 32'h0);
      chk("init.busy_a", {31'd0, busy_a}, 32'h0);
      chk("init.wr_count", {16'd0, wr_count}, 32'h0);
      @(negedge clk);
      #3 clr = 1'b0;

      drive(1, 3, 32'h12345678, 0, 0, 3, 3);
`ifdef NEG_REGFILE_BYPASS_EN
      chk("wr3.pre", rdata_a, 32'h12345678);
`else
      chk("wr3.pre", rdata_a, 32'h0);
`endif
      commit("wr3");
      chk("wr3.count_is_1", {16'd0, wr_count}, 32'h1);

      drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
      commit("zero");
      chk("zero.rdata_is_0", rdata_a, 32'h0);
      chk("zero.nz_rdata", nz_rdata_a, 32'hFFFFFFFF);

      drive(0, 0, 0, 1, 7, 7, 7);
      commit("bset7");
      chk("bset7.busy", {31'd0, busy_a}, 32'h1);
      drive(1, 7, 32'h0BADF00D, 0, 0, 7, 7);
      commit("wr7");
      chk("wr7.busy_clear", {31'd0, busy_a}, 32'h0);
      drive(1, 7, 32'hCAFEBABE, 1, 7, 7, 7);
      commit("wrset7");
      chk("wrset7.busy_wins", {31'd0, busy_b}, 32'h1);

      drive(1, 9, 32'h11111111, 0, 0, 9, 9);
      commit("wr9");
      drive(1, 9, 32'hA5A5A5A5, 0, 0, 3, 9);
`ifdef NEG_REGFILE_BYPASS_EN
      chk("byp9.pre_b", rdata_b, 32'hA5A5A5A5);
`else
      chk("byp9.pre_b", rdata_b, 32'h11111111);
`endif
      chk("byp9.pre_a", rdata_a, 32'h12345678);
      commit("byp9");

      for (int i = 0; i < 24; i++) begin
         drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         commit("rnd");
      end

      drive(1, 5, 32'hDEADBEEF, 1, 11, 5, 11);
      commit("wr5");
      #2 clr = 1'b1;
      model_reset();
      #1;
      chk("clr.rdata5", rdata_a, 32'h0);
      chk("clr.busy11", {31'd0, busy_b}, 32'h0);
      chk("clr.wr_count", {16'd0, wr_count}, 32'h0);
      chk("clr.nz_wr_count", {16'd0, nz_wr_count}, 32'h0);

      drive(1, 4, 32'h77777777, 1, 4, 4, 4);
      @(negedge clk);
      #1;
      we       = 1'b0;
      busy_set = 1'b0;
      #1;
      chk("clrhold.rdata4", rdata_a, 32'h0);
      chk("clrhold.busy4", {31'd0, busy_a}, 32'h0);
      chk("clrhold.wr_count", {16'd0, wr_count}, 32'h0);
      #2 clr = 1'b0;
      drive(1, 4, 32'h44440004, 0, 0, 4, 3);
      commit("post_clr");

      drive(1, 1, 32'h5A5A0001, 0, 0, 1, 0);
      repeat (65540) begin
         @(negedge clk);
         m_cnt  = sat(m_cnt);
         nz_cnt = sat(nz_cnt);
      end
      m_mem[1] = 32'h5A5A0001;
      m_busy[1] = 1'b0;
      commit("sat");
      chk("sat.wr_count", {16'd0, wr_count}, 32'h0000FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
